// File: rtl/i2si_rx_fifo.sv
// I2S receive buffer: picks the BIST or deserializer sample stream and queues it
// in a DEPTH-entry show-ahead FIFO drained over a valid/ready handshake.
module i2si_rx_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rf_bist_en,
  input  logic [31:0]   i2si_rx_data,
  input  logic          i2si_rx_xfc,
  input  logic [31:0]   i2si_bist_out_data,
  input  logic          i2si_bist_out_xfc,
  input  logic          rf_fifo_clr,
  input  logic          rf_ovf_clr,
  output logic [31:0]   fifo_out_data,
  output logic          fifo_out_valid,
  input  logic          fifo_out_ready,
  output logic [AW:0]   fifo_level,
  output logic          fifo_full,
  output logic          fifo_ovf
);

  logic          src_sel_q, src_sel_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   mem [DEPTH];

  logic          flush, wr_req, pop_req, wr_en, pop, full;
  logic [31:0]   wr_data;

  always_comb begin
    src_sel_d = rf_bist_en;
    // A source switch flushes so samples from the two streams never mix.
    flush     = rf_fifo_clr | (src_sel_q != rf_bist_en);
    wr_req    = src_sel_q ? i2si_bist_out_xfc  : i2si_rx_xfc;
    wr_data   = src_sel_q ? i2si_bist_out_data : i2si_rx_data;
    full      = (level_q == (AW+1)'(DEPTH));
    pop_req   = (level_q != '0) & fifo_out_ready;
    wr_en     = wr_req & (~full | pop_req) & ~flush;
    pop       = pop_req & ~flush;

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end

    // Set dominates clear; a flush leaves the sticky flag alone.
    if (wr_req & full & ~pop_req) ovf_d = 1'b1;
    else if (rf_ovf_clr)          ovf_d = 1'b0;
    else                          ovf_d = ovf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_sel_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      src_sel_q <= src_sel_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data;
  end

  assign fifo_out_data  = mem[rd_ptr_q];
  assign fifo_out_valid = (level_q != '0);
  assign fifo_level     = level_q;
  assign fifo_full      = full;
  assign fifo_ovf       = ovf_q;

endmodule

// File: tb/tb_i2si_rx_fifo.sv
// Bench for i2si_rx_fifo: vector table for fill/overflow/drain plus hand-written
// sequences, with a queue scoreboard holding the samples expected at the head.
module tb_i2si_rx_fifo;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rf_bist_en;
  logic [31:0] i2si_rx_data;
  logic        i2si_rx_xfc;
  logic [31:0] i2si_bist_out_data;
  logic        i2si_bist_out_xfc;
  logic        rf_fifo_clr;
  logic        rf_ovf_clr;
  logic [31:0] fifo_out_data;
  logic        fifo_out_valid;
  logic        fifo_out_ready;
  logic [AW:0] fifo_level;
  logic        fifo_full;
  logic        fifo_ovf;

  i2si_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rf_bist_en(rf_bist_en),
    .i2si_rx_data(i2si_rx_data), .i2si_rx_xfc(i2si_rx_xfc),
    .i2si_bist_out_data(i2si_bist_out_data), .i2si_bist_out_xfc(i2si_bist_out_xfc),
    .rf_fifo_clr(rf_fifo_clr), .rf_ovf_clr(rf_ovf_clr),
    .fifo_out_data(fifo_out_data), .fifo_out_valid(fifo_out_valid),
    .fifo_out_ready(fifo_out_ready), .fifo_level(fifo_level),
    .fifo_full(fifo_full), .fifo_ovf(fifo_ovf)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] sb [$];
  logic        m_sel  = 1'b0;
  logic        m_ovf  = 1'b0;

  typedef struct {
    logic        rx_x;
    logic [31:0] rx_d;
    logic        rdy;
    logic        oclr;
    logic [AW:0] exp_level;
    logic        exp_full;
    logic        exp_ovf;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, check the popped head before the edge, then
  // advance the scoreboard and compare registered state after the edge.
  task automatic cyc(input logic rx_x, input logic [31:0] rx_d,
                     input logic bx, input logic [31:0] bd, input logic ben,
                     input logic rdy, input logic clr, input logic oclr);
    logic flush, wreq, full, pop;
    logic [31:0] wd;
    i2si_rx_xfc = rx_x; i2si_rx_data = rx_d;
    i2si_bist_out_xfc = bx; i2si_bist_out_data = bd;
    rf_bist_en = ben; fifo_out_ready = rdy;
    rf_fifo_clr = clr; rf_ovf_clr = oclr;
    flush = clr || (m_sel != ben);
    wreq  = m_sel ? bx : rx_x;
    wd    = m_sel ? bd : rx_d;
    full  = (sb.size() == DEPTH);
    pop   = rdy && (sb.size() > 0);
    #1;
    if (pop) chk("head_data", fifo_out_data, sb[0]);
    @(posedge clk);
    if (wreq && full && !pop) m_ovf = 1'b1;
    else if (oclr)            m_ovf = 1'b0;
    if (flush) sb.delete();
    else begin
      if (pop) void'(sb.pop_front());
      if (wreq && (!full || pop)) sb.push_back(wd);
    end
    m_sel = ben;
    #1;
    chk("level", 32'(fifo_level), 32'(sb.size()));
    chk("ovf",   32'(fifo_ovf),   32'(m_ovf));
    chk("valid", 32'(fifo_out_valid), 32'(sb.size() > 0));
    chk("full",  32'(fifo_full),  32'(sb.size() == DEPTH));
  endtask

  task automatic rx_put(input logic [31:0] d);
    cyc(1'b1, d, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n, input logic ben);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0, 32'h0, ben, 1'b1, 1'b0, 1'b0);
  endtask

  vec_t vt [$];

  initial begin
    rst_n = 1'b0; rf_bist_en = 1'b0; i2si_rx_xfc = 1'b0; i2si_rx_data = '0;
    i2si_bist_out_xfc = 1'b0; i2si_bist_out_data = '0;
    rf_fifo_clr = 1'b0; rf_ovf_clr = 1'b0; fifo_out_ready = 1'b0;

    // Fill to full, overflow, drain in order, clear overflow.
    for (int i = 1; i <= 8; i++)
      vt.push_back('{1'b1, 32'(i), 1'b0, 1'b0, (AW+1)'(i), (i == 8), 1'b0});
    vt.push_back('{1'b1, 32'h9, 1'b0, 1'b0, 4'd8, 1'b1, 1'b1});
    for (int i = 1; i <= 8; i++)
      vt.push_back('{1'b0, 32'h0, 1'b1, 1'b0, (AW+1)'(8 - i), 1'b0, 1'b1});
    vt.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0});

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(fifo_out_valid), 32'h0);
    chk("rst_level", 32'(fifo_level), 32'h0);
    chk("rst_full",  32'(fifo_full), 32'h0);
    chk("rst_ovf",   32'(fifo_ovf), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      if (i == 8) chk("full_head", fifo_out_data, 32'h1);
      cyc(vt[i].rx_x, vt[i].rx_d, 1'b0, 32'h0, 1'b0, vt[i].rdy, 1'b0, vt[i].oclr);
      chk($sformatf("vec%0d_level", i), 32'(fifo_level), 32'(vt[i].exp_level));
      chk($sformatf("vec%0d_full", i),  32'(fifo_full),  32'(vt[i].exp_full));
      chk($sformatf("vec%0d_ovf", i),   32'(fifo_ovf),   32'(vt[i].exp_ovf));
    end

    // Write and pop together while full: level holds, no overflow.
    for (int i = 0; i < 8; i++) rx_put(32'h100 + 32'(i));
    cyc(1'b1, 32'hAAAA_5555, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("wp_level", 32'(fifo_level), 32'd8);
    chk("wp_ovf",   32'(fifo_ovf), 32'h0);
    drain(7, 1'b0);
    chk("wp_last_head", fifo_out_data, 32'hAAAA_5555);
    drain(1, 1'b0);

    // Switch to BIST, then interleave both sources: only BIST samples enter.
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 32'hFEFF_0100, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hDEAD_0001, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 32'hFDFF_0200, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hDEAD_0002, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("iso_level", 32'(fifo_level), 32'd2);
    chk("iso_head",  fifo_out_data, 32'hFEFF_0100);
    drain(2, 1'b1);

    // Mode change with 3 queued and overflow set; xfc in flush cycle is lost.
    for (int i = 0; i < 9; i++)
      cyc(1'b0, 32'h0, 1'b1, 32'hB000 + 32'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    drain(5, 1'b1);
    chk("mc_pre_level", 32'(fifo_level), 32'd3);
    cyc(1'b1, 32'hC0DE_0001, 1'b1, 32'hB0FF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mc_level", 32'(fifo_level), 32'd0);
    chk("mc_ovf",   32'(fifo_ovf), 32'h1);
    rx_put(32'hC0DE_0002);
    chk("mc_new_head", fifo_out_data, 32'hC0DE_0002);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("mc_ovf_clr", 32'(fifo_ovf), 32'h0);

    // Explicit clear while a write and pop are requested.
    for (int i = 0; i < 3; i++) rx_put(32'hE0 + 32'(i));
    cyc(1'b1, 32'hE9, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("clr_level", 32'(fifo_level), 32'd0);

    // Reset mid-transfer with level 5 (after an overflow) and ready high.
    for (int i = 0; i < 9; i++) rx_put(32'h50 + 32'(i));
    drain(3, 1'b0);
    chk("pre_rst_level", 32'(fifo_level), 32'd5);
    fifo_out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(fifo_out_valid), 32'h0);
    chk("rst_mid_level", 32'(fifo_level), 32'h0);
    chk("rst_mid_ovf",   32'(fifo_ovf), 32'h0);
    sb.delete(); m_ovf = 1'b0; m_sel = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(1'b1, 32'h7777_0001, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_level", 32'(fifo_level), 32'd1);
    chk("post_rst_head",  fifo_out_data, 32'h7777_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
